// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side client: default word width, reader FSM
// states and the per-word frame flags.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;

  typedef enum logic {
    BODY = 1'b0,
    CSUM = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic sof;
    logic eof;
  } frame_flags_t;

endpackage

// File: rtl/fifo_reader_out_reg.sv
// Single-entry output register of the frame stream. It takes a new word whenever
// it is empty or its current word is being accepted downstream.
module fifo_reader_out_reg
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clock_out,
  input  logic                  rst_out,
  input  logic                  ld_en,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  frame_flags_t          ld_flags,
  input  logic                  m_ready,
  output logic                  load,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_sof,
  output logic                  m_eof
);

  assign load = !m_valid || m_ready;

  // Output stage: holds steady while stalled, empties when nothing is offered.
  always_ff @(posedge clock_out) begin
    if (rst_out) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (load) begin
      m_valid <= ld_en;
      if (ld_en) begin
        m_data <= ld_data;
        m_sof  <= ld_flags.sof;
        m_eof  <= ld_flags.eof;
      end
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side FIFO client: pops show-ahead words and repacks them into fixed-length
// sof/eof frames. Define FIFO_READER_CHECKSUM_EN to append a modular-sum word.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int FRAME_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock_out,
  input  logic                  rst_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_out_valid,
  output logic                  data_out_ack,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int WC_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_LEN - 1);

  logic                  load;
  logic                  ld_en;
  logic [DATA_WIDTH-1:0] ld_data;
  frame_flags_t          ld_flags;
  logic [WC_W-1:0]       word_cnt;
  logic [WC_W-1:0]       word_cnt_nxt;
  logic                  last_word;

  assign last_word = (word_cnt == LAST_IDX);

`ifdef FIFO_READER_CHECKSUM_EN
  rd_state_t             state;
  rd_state_t             state_nxt;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_nxt;

  always_ff @(posedge clock_out) begin
    if (rst_out) begin
      state    <= BODY;
      word_cnt <= '0;
      sum      <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      sum      <= sum_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    sum_nxt      = sum;
    data_out_ack = 1'b0;
    ld_en        = 1'b0;
    ld_data      = data_out;
    ld_flags     = '0;
    case (state)
      BODY: begin
        data_out_ack = data_out_valid && load && !rst_out;
        if (data_out_ack) begin
          ld_en        = 1'b1;
          ld_flags.sof = (word_cnt == '0);
          sum_nxt      = sum + data_out;
          word_cnt_nxt = word_cnt + WC_W'(1);
          if (last_word) state_nxt = CSUM;
        end
      end
      CSUM: begin
        // No pop here: this slot carries the sum including the final data word.
        if (load) begin
          ld_en        = 1'b1;
          ld_data      = sum;
          ld_flags.eof = 1'b1;
          sum_nxt      = '0;
          word_cnt_nxt = '0;
          state_nxt    = BODY;
        end
      end
      default: state_nxt = BODY;
    endcase
  end
`else
  always_ff @(posedge clock_out) begin
    if (rst_out) word_cnt <= '0;
    else         word_cnt <= word_cnt_nxt;
  end

  always_comb begin
    data_out_ack = data_out_valid && load && !rst_out;
    ld_en        = data_out_ack;
    ld_data      = data_out;
    ld_flags.sof = (word_cnt == '0);
    ld_flags.eof = last_word;
    word_cnt_nxt = word_cnt;
    if (data_out_ack) word_cnt_nxt = last_word ? '0 : word_cnt + WC_W'(1);
  end
`endif

  fifo_reader_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clock_out(clock_out),
    .rst_out  (rst_out),
    .ld_en    (ld_en),
    .ld_data  (ld_data),
    .ld_flags (ld_flags),
    .m_ready  (m_ready),
    .load     (load),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_sof    (m_sof),
    .m_eof    (m_eof)
  );

  // A frame is complete once its eof word handshakes downstream.
  always_ff @(posedge clock_out) begin
    if (rst_out)                        frame_count <= '0;
    else if (m_valid && m_ready && m_eof) frame_count <= frame_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a show-ahead FIFO model feeds the DUT and every
// accepted output word is logged for comparison against hand-derived frames.
module tb_fifo_reader;

  localparam int DW   = 32;
  localparam int FLEN = 8;
`ifdef FIFO_READER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int FW = CS ? FLEN + 1 : FLEN;

  logic          clock_out = 1'b0;
  logic          rst_out   = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ack;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready   = 1'b1;
  logic          m_sof;
  logic          m_eof;
  logic [15:0]   frame_count;

  logic          ack2;
  logic [DW-1:0] m_data2;
  logic          m_valid2;
  logic          sof2;
  logic          eof2;
  logic [1:0]    fc2;

  logic [DW-1:0] mem [0:63];
  logic [6:0]    wr_cnt   = '0;
  logic [6:0]    rd_ptr   = '0;
  logic          fifo_clr = 1'b0;
  logic          log_clr  = 1'b0;
  logic [DW-1:0] log_d [0:63];
  logic          log_s [0:63];
  logic          log_e [0:63];
  logic [6:0]    log_n    = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock_out = ~clock_out;

  assign data_out_valid = (rd_ptr < wr_cnt);
  assign data_out       = mem[rd_ptr[5:0]];

  fifo_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FLEN), .CNT_WIDTH(16)) dut (
    .clock_out(clock_out), .rst_out(rst_out), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ack(data_out_ack),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof), .frame_count(frame_count)
  );

  fifo_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FLEN), .CNT_WIDTH(2)) dut_wrap (
    .clock_out(clock_out), .rst_out(rst_out), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ack(ack2),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
    .m_sof(sof2), .m_eof(eof2), .frame_count(fc2)
  );

  always @(posedge clock_out) begin
    if (fifo_clr)          rd_ptr <= '0;
    else if (data_out_ack) rd_ptr <= rd_ptr + 7'd1;
    if (log_clr) log_n <= '0;
    else if (m_valid && m_ready) begin
      log_d[log_n[5:0]] <= m_data;
      log_s[log_n[5:0]] <= m_sof;
      log_e[log_n[5:0]] <= m_eof;
      log_n <= log_n + 7'd1;
    end
  end

  task automatic start();
    @(negedge clock_out);
    rst_out = 1'b1; fifo_clr = 1'b1; log_clr = 1'b1; wr_cnt = '0; m_ready = 1'b1;
    @(negedge clock_out);
    rst_out = 1'b0; fifo_clr = 1'b0; log_clr = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (int'(log_n) < n && k < budget) begin
      @(negedge clock_out);
      k++;
    end
    ok = (int'(log_n) >= n);
  endtask

  task automatic test_reset();
    @(negedge clock_out);
    rst_out = 1'b1; fifo_clr = 1'b1; log_clr = 1'b1; wr_cnt = 7'd8; m_ready = 1'b1;
    @(negedge clock_out);
    #1;
    checks++; if (data_out_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", data_out_ack); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", m_data); end
    checks++; if ({m_sof, m_eof} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {m_sof, m_eof}); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    checks++; if (fc2 !== 2'd0) begin errors++; $display("FAIL reset_count_wrap: got %0d expected 0", fc2); end
    rst_out = 1'b0; fifo_clr = 1'b0; log_clr = 1'b0;
  endtask

  task automatic test_stream();
    logic ackv [0:19];
    logic [15:0] fcv [0:19];
    logic [DW-1:0] exp_d;
    bit exp_a;
    int p;
    start();
    wr_cnt = 7'd16;
    for (int c = 0; c < 20; c++) begin
      #1;
      ackv[c] = data_out_ack;
      fcv[c]  = frame_count;
      @(negedge clock_out);
    end
    for (int c = 0; c < 20; c++) begin
      exp_a = CS ? ((c < 8) || (c >= 9 && c < 17)) : (c < 16);
      checks++; if (ackv[c] !== exp_a) begin errors++; $display("FAIL stream_ack[%0d]: got %b expected %b", c, ackv[c], exp_a); end
    end
    checks++; if (fcv[FW] !== 16'd0) begin errors++; $display("FAIL stream_count_before_eof: got %0d expected 0", fcv[FW]); end
    checks++; if (fcv[FW+1] !== 16'd1) begin errors++; $display("FAIL stream_count_after_eof: got %0d expected 1", fcv[FW+1]); end
    checks++; if (fcv[19] !== 16'd2) begin errors++; $display("FAIL stream_count_two: got %0d expected 2", fcv[19]); end
    checks++; if (int'(log_n) !== 2 * FW) begin errors++; $display("FAIL stream_words: got %0d expected %0d", log_n, 2 * FW); end
    for (int i = 0; i < 2 * FW; i++) begin
      p = i % FW;
      exp_d = (p == FLEN) ? 32'hFF : (32'h1 << p);
      checks++; if (log_d[i] !== exp_d) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, log_d[i], exp_d); end
      checks++; if (log_s[i] !== (p == 0)) begin errors++; $display("FAIL stream_sof[%0d]: got %b expected %b", i, log_s[i], p == 0); end
      checks++; if (log_e[i] !== (p == FW - 1)) begin errors++; $display("FAIL stream_eof[%0d]: got %b expected %b", i, log_e[i], p == FW - 1); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    bit ok;
    start();
    wr_cnt = 7'd8;
    k = 0;
    while (!(m_valid && m_data == 32'h4) && k < 20) begin
      @(negedge clock_out);
      k++;
    end
    checks++; if (!(m_valid && m_data == 32'h4)) begin errors++; $display("FAIL bp_reach_word4: got %h expected 00000004", m_data); end
    m_ready = 1'b0;
    #1;
    checks++; if (data_out_ack !== 1'b0) begin errors++; $display("FAIL bp_ack_start: got %b expected 0", data_out_ack); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clock_out);
      #1;
      checks++; if (m_data !== 32'h4 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b expected 00000004/1", j, m_data, m_valid); end
      checks++; if (data_out_ack !== 1'b0) begin errors++; $display("FAIL bp_ack[%0d]: got %b expected 0", j, data_out_ack); end
    end
    m_ready = 1'b1;
    @(negedge clock_out);
    #1;
    checks++; if (m_data !== 32'h8 || m_valid !== 1'b1 || m_sof !== 1'b0) begin errors++; $display("FAIL bp_resume: got %h/%b/%b expected 00000008/1/0", m_data, m_valid, m_sof); end
    wait_log(FW, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: got %0d words expected %0d", log_n, FW); end
    checks++; if (log_d[FW-1] !== (CS ? 32'hFF : 32'h80) || log_e[FW-1] !== 1'b1) begin errors++; $display("FAIL bp_last: got %h/%b expected %h/1", log_d[FW-1], log_e[FW-1], CS ? 32'hFF : 32'h80); end
  endtask

  task automatic test_empty();
    int nsof;
    bit ok;
    start();
    wr_cnt = 7'd3;
    repeat (3) @(negedge clock_out);
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++; if (data_out_ack !== 1'b0) begin errors++; $display("FAIL empty_ack[%0d]: got %b expected 0", j, data_out_ack); end
      @(negedge clock_out);
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b expected 0", m_valid); end
    wr_cnt = 7'd8;
    wait_log(FW, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_drain: got %0d words expected %0d", log_n, FW); end
    nsof = 0;
    for (int i = 0; i < FW; i++) nsof += int'(log_s[i]);
    checks++; if (nsof !== 1 || log_s[0] !== 1'b1) begin errors++; $display("FAIL empty_sof: got %0d sof expected 1 on word 0", nsof); end
    checks++; if (log_d[FW-1] !== (CS ? 32'hFF : 32'h80) || log_e[FW-1] !== 1'b1) begin errors++; $display("FAIL empty_last: got %h/%b expected %h/1", log_d[FW-1], log_e[FW-1], CS ? 32'hFF : 32'h80); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL empty_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_reset_mid();
    int k;
    start();
    wr_cnt = 7'd6;
    k = 0;
    while (!(m_valid && m_data == 32'h20) && k < 20) begin
      @(negedge clock_out);
      k++;
    end
    checks++; if (!(m_valid && m_data == 32'h20)) begin errors++; $display("FAIL rstmid_reach: got %h expected 00000020", m_data); end
    m_ready = 1'b0; rst_out = 1'b1; wr_cnt = 7'd8;
    @(negedge clock_out);
    rst_out = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", m_valid); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", frame_count); end
    m_ready = 1'b1;
    k = 0;
    while (!m_valid && k < 10) begin
      @(negedge clock_out);
      k++;
    end
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h40) begin errors++; $display("FAIL rstmid_next: got %h/%b expected 00000040/1", m_data, m_valid); end
    checks++; if (m_sof !== 1'b1) begin errors++; $display("FAIL rstmid_sof: got %b expected 1", m_sof); end
  endtask

  task automatic test_wrap();
    bit ok;
    start();
    wr_cnt = 7'(5 * FLEN);
    wait_log(5 * FW, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: got %0d words expected %0d", log_n, 5 * FW); end
    #1;
    checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL wrap_count16: got %0d expected 5", frame_count); end
    checks++; if (fc2 !== 2'd1) begin errors++; $display("FAIL wrap_count2: got %0d expected 1", fc2); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1 << (i % 8);
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Single-clock read-side client of the dual-clock `fifo`: drains words through the `data_out`/`data_out_valid`/`data_out_ack` pop interface and repacks them into fixed-length frames on a valid/ready stream.
- Frames carry start-of-frame and end-of-frame flags.
- Each frame can optionally be terminated by a checksum word.
- The block runs in the FIFO's read clock domain (`clock_out`) and is the counterpart to the write-side producer.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; matches `fifo`.
- `FRAME_LEN`, 8: data words per frame; legal range 2..256.
- `CNT_WIDTH`, 16: width of `frame_count`.

Ports:
- `clock_out`  in  1: read-domain clock; all logic on its rising edge.
- `rst_out`  in  1: synchronous, active-high reset.
- `data_out`  in  DATA_WIDTH: FIFO head word, valid while `data_out_valid`.
- `data_out_valid`  in  1: FIFO non-empty; head word presented (show-ahead).
- `data_out_ack`  out  1: pop strobe; head consumed at this clock edge.
- `m_data`  out  DATA_WIDTH: frame word.
- `m_valid`  out  1: `m_data`/flags valid.
- `m_ready`  in  1: downstream accepts on `m_valid && m_ready`.
- `m_sof`  out  1: first word of frame.
- `m_eof`  out  1: last word of frame.
- `frame_count`  out  CNT_WIDTH: completed frames; a frame completes when its eof word is accepted; wraps modulo 2^CNT_WIDTH.

## Operation
- Output register: one stage holding `m_data`/`m_sof`/`m_eof`/`m_valid`.
  - `load = !m_valid || m_ready`.
  - When `load` and nothing to load: `m_valid` goes 0.
- FSM states:
  - BODY:
    - `data_out_ack = data_out_valid && load` (combinational from registered state and inputs).
    - On ack:
      - Register `data_out` into the output stage.
      - `m_sof = (word_cnt == 0)`.
      - `sum += data_out`, modulo 2^DATA_WIDTH.
      - `word_cnt++`.
    - On the ack of word `FRAME_LEN-1`:
      - Checksum enabled: `m_eof = 0`, go to CSUM.
      - Checksum disabled: `m_eof = 1`, `word_cnt = 0`, `sum = 0`, stay in BODY.
  - CSUM:
    - `data_out_ack = 0`.
    - When `load`: load `m_data = sum` (including the last data word), `m_sof = 0`, `m_eof = 1`; clear `sum` and `word_cnt`; go to BODY.
- Empty FIFO mid-frame: hold state and count indefinitely; no timeout, no partial frames.
- Stall (`m_valid && !m_ready`):
  - `data_out_ack` is 0.
  - `m_data` and the flags stay stable.
  - The FIFO head is untouched.
- Reset mid-frame:
  - Partial frame discarded; `m_valid` drops the cycle after reset is sampled.
  - Words still in the FIFO are not flushed; the next word after reset becomes sof.

## Timing
- Reset values:
  - `data_out_ack = 0`, `m_valid = 0`, `m_data = 0`, `m_sof = 0`, `m_eof = 0`, `frame_count = 0`.
  - State BODY, `word_cnt = 0`, `sum = 0`.
  - During reset, `data_out_ack` is forced to 0.
- Latency: a word popped at edge N is on `m_data` with `m_valid = 1` from edge N to edge N+1; one cycle.
- Throughput:
  - 1 word/cycle with `data_out_valid` and `m_ready` held high.
  - With checksum: FRAME_LEN+1 cycles per frame, one pop bubble during CSUM.
- `frame_count` increments at the edge where the eof word handshakes (`m_valid && m_ready && m_eof`).
- Simultaneous accept and load in the same cycle is legal and sustains full rate.

## Configuration
- Macro: `FIFO_READER_CHECKSUM_EN`.
- Defined:
  - CSUM state exists.
  - Frames are FRAME_LEN data words plus one trailing checksum word carrying eof.
- Undefined:
  - No CSUM state and no `sum` register.
  - Frames are exactly FRAME_LEN words; the last data word carries eof.

## Structure
- Shared package `fifo_pkg`:
  - `DATA_WIDTH` default constant.
  - FSM state typedef (BODY, CSUM).
  - Frame flag struct (sof, eof).
- Sub-module `fifo_reader_out_reg`: the single-entry output register with `load` generation; the FSM, counters and checksum stay in `fifo_reader`.

## Test plan
Stimulus data 1, 2, 4, …, 0x80, `FRAME_LEN = 8` unless noted.
- Streaming, checksum enabled, `m_ready = 1`:
  - 8 words out, sof on 0x1.
  - Ninth word 0x000000FF with eof.
  - `frame_count = 1` after the eof handshake.
  - Exactly one ack-low bubble.
- Same stream, checksum disabled:
  - eof on 0x80.
  - 8 acks in 8 consecutive cycles.
  - Second frame sof on the ninth input word.
- Backpressure: `m_ready` low for 3 cycles after word 0x4 loads:
  - `m_data` holds 0x4 and `data_out_ack = 0` throughout.
  - 0x8 appears the cycle after `m_ready` rises.
- Empty FIFO mid-frame:
  - `data_out_valid` low for 5 cycles after word 3.
  - Then resume: no extra sof; checksum still 0xFF.
- `rst_out` asserted for one cycle after word 5:
  - `m_valid = 0` next cycle; `frame_count = 0`.
  - Next popped word (0x40) carries sof.
- Wrap: `CNT_WIDTH = 2`, 5 frames → `frame_count` reads 1.
